// File: rtl/instr_register_if.sv
// Bus bundle between the controller/ROM side and the instruction register:
// fetch/load strobes and data in, committed instruction fields and status out.
interface instr_register_if #(
  parameter int DATA_W = 8,
  parameter int OP_W   = 3,
  parameter int ADDR_W = 13
);
  logic              fetch;
  logic              ena;
  logic              flush;
  logic [DATA_W-1:0] data;
  logic [OP_W-1:0]   opcode;
  logic [ADDR_W-1:0] ir_addr;
  logic              ir_valid;
  logic              ir_load;
  logic              busy;

  modport master (
    output fetch, ena, flush, data,
    input  opcode, ir_addr, ir_valid, ir_load, busy
  );

  modport slave (
    input  fetch, ena, flush, data,
    output opcode, ir_addr, ir_valid, ir_load, busy
  );
endinterface

// File: rtl/instr_register.sv
// Instruction register: assembles a 2*DATA_W instruction from two bus bytes
// (MSB first) and commits opcode/ir_addr atomically on the low-byte edge.
module instr_register #(
  parameter int DATA_W = 8,
  parameter int OP_W   = 3,
  parameter int ADDR_W = 13
) (
  input logic             clk,
  input logic             rst_n,
  instr_register_if.slave bus
);

  if (OP_W + ADDR_W != 2 * DATA_W) begin : g_width_check
    $fatal(1, "instr_register: OP_W + ADDR_W must equal 2*DATA_W");
  end

  typedef enum logic {S_HI = 1'b0, S_LO = 1'b1} state_t;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [ADDR_W-1:0] addr;
  } instr_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] hi_buf, hi_buf_nxt;
  instr_t            ir, ir_nxt;
  logic              valid, valid_nxt;
  logic              load, load_nxt;
  logic              cap;

  // flush outranks a capture in the same cycle
  assign cap = bus.ena & bus.fetch & ~bus.flush;

  always_comb begin
    state_nxt  = state;
    hi_buf_nxt = hi_buf;
    ir_nxt     = ir;
    valid_nxt  = valid;
    load_nxt   = 1'b0;
    case (state)
      S_HI: begin
        if (bus.flush) begin
          valid_nxt = 1'b0;
        end else if (cap) begin
          hi_buf_nxt = bus.data;
          valid_nxt  = 1'b0;
          state_nxt  = S_LO;
        end
      end
      S_LO: begin
        if (bus.flush) begin
          hi_buf_nxt = '0;
          valid_nxt  = 1'b0;
          state_nxt  = S_HI;
        end else if (cap) begin
          // both halves land in the same edge, so no torn instruction is visible
          ir_nxt    = instr_t'({hi_buf, bus.data});
          valid_nxt = 1'b1;
          load_nxt  = 1'b1;
          state_nxt = S_HI;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_HI;
      hi_buf <= '0;
      ir     <= '0;
      valid  <= 1'b0;
      load   <= 1'b0;
    end else begin
      state  <= state_nxt;
      hi_buf <= hi_buf_nxt;
      ir     <= ir_nxt;
      valid  <= valid_nxt;
      load   <= load_nxt;
    end
  end

  assign bus.opcode   = ir.op;
  assign bus.ir_addr  = ir.addr;
  assign bus.ir_valid = valid;
  assign bus.ir_load  = load;
  // decoded straight from the single state flop, so it cannot glitch
  assign bus.busy     = (state == S_LO);

endmodule

// File: tb/tb_instr_register.sv
// Randomized + directed bench for instr_register against a byte-queue model.
module tb_instr_register;
  localparam int DATA_W = 8;
  localparam int OP_W   = 3;
  localparam int ADDR_W = 13;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instr_register_if #(.DATA_W(DATA_W), .OP_W(OP_W), .ADDR_W(ADDR_W)) bus();

  instr_register #(.DATA_W(DATA_W), .OP_W(OP_W), .ADDR_W(ADDR_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: bytes captured for the instruction in progress sit in a queue;
  // a second byte completes the word.
  logic [DATA_W-1:0]   q[$];
  logic [2*DATA_W-1:0] m_word  = '0;
  logic                m_valid = 1'b0;
  logic                m_load  = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_word  = '0;
      m_valid = 1'b0;
      m_load  = 1'b0;
    end else begin
      m_load = 1'b0;
      if (bus.flush) begin
        q.delete();
        m_valid = 1'b0;
      end else if (bus.ena && bus.fetch) begin
        q.push_back(bus.data);
        if (q.size() == 2) begin
          m_word  = {q[0], q[1]};
          q.delete();
          m_valid = 1'b1;
          m_load  = 1'b1;
        end else begin
          m_valid = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("opcode",   32'(bus.opcode),   32'(m_word[2*DATA_W-1 -: OP_W]));
    chk("ir_addr",  32'(bus.ir_addr),  32'(m_word[ADDR_W-1:0]));
    chk("ir_valid", 32'(bus.ir_valid), 32'(m_valid));
    chk("ir_load",  32'(bus.ir_load),  32'(m_load));
    chk("busy",     32'(bus.busy),     32'(q.size() == 1));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cap(input logic [7:0] b);
    bus.fetch = 1'b1; bus.ena = 1'b1; bus.flush = 1'b0; bus.data = b;
    step();
    bus.ena = 1'b0;
  endtask

  task automatic pin(input string name, input logic [2:0] op, input logic [12:0] addr,
                     input logic v, input logic ld, input logic bz);
    chk({name, "_op"},   32'(bus.opcode),   32'(op));
    chk({name, "_addr"}, 32'(bus.ir_addr),  32'(addr));
    chk({name, "_vld"},  32'(bus.ir_valid), 32'(v));
    chk({name, "_ld"},   32'(bus.ir_load),  32'(ld));
    chk({name, "_busy"}, 32'(bus.busy),     32'(bz));
  endtask

  initial begin
    bus.fetch = 1'b0; bus.ena = 1'b0; bus.flush = 1'b0; bus.data = '0;
    step(); step();
    pin("reset", 3'd0, 13'h0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step();

    // basic two-byte fetch
    cap(8'hA5);
    pin("hi_a5", 3'd0, 13'h0, 1'b0, 1'b0, 1'b1);
    cap(8'h3C);
    pin("commit_a53c", 3'b101, 13'h053C, 1'b1, 1'b1, 1'b0);
    chk("model_word", 32'(m_word), 32'hA53C);
    step();
    pin("load_drop", 3'b101, 13'h053C, 1'b1, 1'b0, 1'b0);

    // gap between bytes
    cap(8'hFF);
    repeat (5) step();
    pin("gap", 3'b101, 13'h053C, 1'b0, 1'b0, 1'b1);
    cap(8'h01);
    pin("commit_ff01", 3'b111, 13'h1F01, 1'b1, 1'b1, 1'b0);

    // flush mid-fetch
    cap(8'hA5); cap(8'h3C);
    cap(8'h40);
    bus.flush = 1'b1; bus.ena = 1'b1; bus.fetch = 1'b1; bus.data = 8'h99;
    step();
    bus.flush = 1'b0; bus.ena = 1'b0;
    pin("flushed", 3'b101, 13'h053C, 1'b0, 1'b0, 1'b0);
    cap(8'h12); cap(8'h34);
    pin("commit_1234", 3'b000, 13'h1234, 1'b1, 1'b1, 1'b0);

    // ena without fetch
    bus.fetch = 1'b0; bus.ena = 1'b1; bus.data = 8'hEE;
    repeat (4) step();
    bus.ena = 1'b0;
    pin("no_fetch", 3'b000, 13'h1234, 1'b1, 1'b0, 1'b0);

    // async reset while busy
    cap(8'h55);
    #3 rst_n = 1'b0;
    #1 pin("async_rst", 3'd0, 13'h0, 1'b0, 1'b0, 1'b0);
    step();
    rst_n = 1'b1;
    cap(8'h20); cap(8'h08);
    pin("commit_2008", 3'b001, 13'h0008, 1'b1, 1'b1, 1'b0);

    // back-to-back captures
    for (int i = 1; i <= 8; i++) cap(8'(i));
    pin("b2b_last", 3'b000, 13'h0708, 1'b1, 1'b1, 1'b0);
    chk("model_b2b", 32'(m_word), 32'h0708);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      bus.fetch = ($urandom_range(0, 3) != 0);
      bus.ena   = ($urandom_range(0, 2) != 0);
      bus.flush = ($urandom_range(0, 15) == 0);
      bus.data  = 8'($urandom);
      step();
    end
    bus.ena = 1'b0; bus.flush = 1'b0;
    step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
